// File: rtl/fetch_pkg.sv
// Shared branch-prediction definitions for the fetch front end:
// 2-bit counter encodings and the saturating counter update rule.
package fetch_pkg;

   typedef logic [1:0] cnt_t;

   localparam cnt_t SNT = 2'd0;
   localparam cnt_t WNT = 2'd1;
   localparam cnt_t WT  = 2'd2;
   localparam cnt_t ST  = 2'd3;

   // Unconditional jumps pin the counter to strongly-taken.
   function automatic cnt_t sat_update(input cnt_t cnt, input logic taken, input logic uncond);
      cnt_t r;
      if (uncond) begin
         r = ST;
      end else if (taken) begin
         case (cnt)
            SNT:     r = WNT;
            WNT:     r = WT;
            default: r = ST;
         endcase
      end else begin
         case (cnt)
            ST:      r = WT;
            WT:      r = WNT;
            default: r = SNT;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer: comb lookup port and a
// read-modify-write training port that commits at the clock edge.
module btb_table
   import fetch_pkg::*;
#(
   parameter  int ADDR_W  = 32,
   parameter  int ENTRIES = 16,
   localparam int IDX_W   = $clog2(ENTRIES),
   localparam int TAG_W   = ADDR_W - IDX_W - 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  i_rd_idx,
   input  logic [TAG_W-1:0]  i_rd_tag,
   output logic              o_rd_taken,
   output logic [ADDR_W-1:0] o_rd_target,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [TAG_W-1:0]  i_wr_tag,
   input  logic              i_wr_taken,
   input  logic              i_wr_uncond,
   input  logic [ADDR_W-1:0] i_wr_target
);

   typedef struct packed {
      logic              valid;
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] target;
      cnt_t              cnt;
   } btb_entry_t;

   btb_entry_t r_tab [ENTRIES];
   btb_entry_t w_rd_ent;
   btb_entry_t w_wr_old;
   btb_entry_t w_wr_new;
   logic       w_wr_hit;
   logic       w_wr_commit;

   assign w_rd_ent    = r_tab[i_rd_idx];
   assign o_rd_taken  = w_rd_ent.valid && (w_rd_ent.tag == i_rd_tag) && w_rd_ent.cnt[1];
   assign o_rd_target = w_rd_ent.target;

   assign w_wr_old = r_tab[i_wr_idx];
   assign w_wr_hit = w_wr_old.valid && (w_wr_old.tag == i_wr_tag);

   // A not-taken outcome on a miss leaves the entry alone; a taken miss
   // allocates over whatever alias currently occupies the slot.
   always_comb begin
      w_wr_new    = w_wr_old;
      w_wr_commit = 1'b0;
      if (i_wr_en) begin
         if (w_wr_hit) begin
            w_wr_commit  = 1'b1;
            w_wr_new.cnt = sat_update(w_wr_old.cnt, i_wr_taken, i_wr_uncond);
            if (i_wr_taken) w_wr_new.target = i_wr_target;
         end else if (i_wr_taken) begin
            w_wr_commit     = 1'b1;
            w_wr_new.valid  = 1'b1;
            w_wr_new.tag    = i_wr_tag;
            w_wr_new.target = i_wr_target;
            w_wr_new.cnt    = i_wr_uncond ? ST : WT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) r_tab[i] <= '0;
      end else if (w_wr_commit) begin
         r_tab[i_wr_idx] <= w_wr_new;
      end
   end

endmodule

// File: rtl/fetch_pc_btb.sv
// PC generation with BTB prediction in F, decode-stage mispredict
// correction and BTB training, and a saturating mispredict counter.
module fetch_pc_btb
   import fetch_pkg::*;
#(
   parameter int              ADDR_W      = 32,
   parameter int              BTB_ENTRIES = 16,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int              CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pcD_o,
   output logic              validD_o,
   output logic              pred_takenD_o,
   output logic [ADDR_W-1:0] pred_targetD_o,
   input  logic              res_valid_i,
   input  logic              res_taken_i,
   input  logic              res_uncond_i,
   input  logic [ADDR_W-1:0] res_target_i,
   output logic              flush_o,
   output logic [CNT_W-1:0]  mispred_cnt_o
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pcd;
   logic              r_validd;
   logic              r_pred_takend;
   logic [ADDR_W-1:0] r_pred_targetd;
   logic [CNT_W-1:0]  r_mis_cnt;

   logic              w_pred_taken;
   logic [ADDR_W-1:0] w_pred_target;
   logic [ADDR_W-1:0] w_pred_next;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_mis;
   logic              w_train;

   btb_table #(
      .ADDR_W  (ADDR_W),
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst         (rst),
      .i_rd_idx    (r_pc[IDX_W+1:2]),
      .i_rd_tag    (r_pc[ADDR_W-1:IDX_W+2]),
      .o_rd_taken  (w_pred_taken),
      .o_rd_target (w_pred_target),
      .i_wr_en     (w_train),
      .i_wr_idx    (r_pcd[IDX_W+1:2]),
      .i_wr_tag    (r_pcd[ADDR_W-1:IDX_W+2]),
      .i_wr_taken  (res_taken_i),
      .i_wr_uncond (res_uncond_i),
      .i_wr_target (res_target_i)
   );

   assign w_pred_next = w_pred_taken ? w_pred_target : r_pc + ADDR_W'(4);
   assign w_train     = res_valid_i && r_validd;
   assign w_mis       = w_train && ((res_taken_i != r_pred_takend) ||
                                    (res_taken_i && (res_target_i != r_pred_targetd)));

   // Redirect wins over stall so a resolved mispredict is never lost.
   always_comb begin
      w_pc_next = w_pred_next;
      if (w_mis)        w_pc_next = res_taken_i ? res_target_i : r_pcd + ADDR_W'(4);
      else if (stall_i) w_pc_next = r_pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_pc <= RESET_PC;
      else     r_pc <= w_pc_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcd          <= '0;
         r_validd       <= 1'b0;
         r_pred_takend  <= 1'b0;
         r_pred_targetd <= '0;
      end else if (w_mis) begin
         r_validd      <= 1'b0;
         r_pred_takend <= 1'b0;
      end else if (!stall_i) begin
         r_pcd          <= r_pc;
         r_validd       <= 1'b1;
         r_pred_takend  <= w_pred_taken;
         r_pred_targetd <= w_pred_target;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                     r_mis_cnt <= '0;
      else if (w_mis && (r_mis_cnt != {CNT_W{1'b1}})) r_mis_cnt <= r_mis_cnt + CNT_W'(1);
   end

   assign pc_o           = r_pc;
   assign pcD_o          = r_pcd;
   assign validD_o       = r_validd;
   assign pred_takenD_o  = r_pred_takend;
   assign pred_targetD_o = r_pred_targetd;
   assign flush_o        = w_mis;
   assign mispred_cnt_o  = r_mis_cnt;

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Directed bench for fetch_pc_btb: sequential fetch, BTB allocate/train,
// counter decay, stall with redirect, alias eviction and async reset.
module tb_fetch_pc_btb;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic [31:0] pc_o;
   logic [31:0] pcD_o;
   logic        validD_o;
   logic        pred_takenD_o;
   logic [31:0] pred_targetD_o;
   logic        res_valid_i;
   logic        res_taken_i;
   logic        res_uncond_i;
   logic [31:0] res_target_i;
   logic        flush_o;
   logic [31:0] mispred_cnt_o;

   int checks = 0;
   int errors = 0;

   fetch_pc_btb #(
      .ADDR_W      (32),
      .BTB_ENTRIES (16),
      .RESET_PC    (32'h0),
      .CNT_W       (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .stall_i        (stall_i),
      .pc_o           (pc_o),
      .pcD_o          (pcD_o),
      .validD_o       (validD_o),
      .pred_takenD_o  (pred_takenD_o),
      .pred_targetD_o (pred_targetD_o),
      .res_valid_i    (res_valid_i),
      .res_taken_i    (res_taken_i),
      .res_uncond_i   (res_uncond_i),
      .res_target_i   (res_target_i),
      .flush_o        (flush_o),
      .mispred_cnt_o  (mispred_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic resolve(input logic v, input logic t, input logic u, input logic [31:0] tgt);
      res_valid_i  = v;
      res_taken_i  = t;
      res_uncond_i = u;
      res_target_i = tgt;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      stall_i = 1'b0;
      res_valid_i = 1'b0;
      res_taken_i = 1'b0;
      res_uncond_i = 1'b0;
      res_target_i = '0;
      #2;
      chk("rst_pc",     pc_o, 32'h0);
      chk("rst_pcd",    pcD_o, 32'h0);
      chk("rst_validd", validD_o, 0);
      chk("rst_predt",  pred_takenD_o, 0);
      chk("rst_predtg", pred_targetD_o, 32'h0);
      chk("rst_flush",  flush_o, 0);
      chk("rst_cnt",    mispred_cnt_o, 32'h0);
      tick();
      rst = 1'b0;

      // sequential fetch
      tick(); chk("seq_pc1", pc_o, 32'h4); chk("seq_vd1", validD_o, 1); chk("seq_pcd1", pcD_o, 32'h0);
      tick(); chk("seq_pc2", pc_o, 32'h8);
      tick(); chk("seq_pc3", pc_o, 32'hC);
      tick(); chk("seq_pc4", pc_o, 32'h10);
      tick(); chk("seq_pcd5", pcD_o, 32'h10); chk("seq_predt5", pred_takenD_o, 0);

      // branch at 0x10, BTB miss, resolves taken to 0x40
      resolve(1, 1, 0, 32'h40);
      chk("br_flush", flush_o, 1);
      tick(); resolve(0, 0, 0, 0);
      chk("br_pc", pc_o, 32'h40); chk("br_vd", validD_o, 0); chk("br_cnt", mispred_cnt_o, 1);

      // 0x40 is a jump back to 0x10
      tick(); chk("j40_pcd", pcD_o, 32'h40);
      resolve(1, 1, 1, 32'h10);
      chk("j40_flush", flush_o, 1);
      tick(); resolve(0, 0, 0, 0);
      chk("j40_pc", pc_o, 32'h10); chk("j40_cnt", mispred_cnt_o, 2);

      // re-fetch 0x10 now predicted taken (cnt=2)
      tick(); chk("pt_pc", pc_o, 32'h40); chk("pt_predt", pred_takenD_o, 1);
      chk("pt_predtg", pred_targetD_o, 32'h40);
      resolve(1, 1, 0, 32'h40);
      chk("pt_flush", flush_o, 0);
      tick(); resolve(0, 0, 0, 0);
      chk("pt_pc_loop", pc_o, 32'h10); chk("pt_cnt", mispred_cnt_o, 2);

      // 0x10 resolves not taken: first time (cnt 3->2)
      tick(); chk("nt1_predt", pred_takenD_o, 1);
      resolve(1, 0, 0, 0);
      chk("nt1_flush", flush_o, 1);
      tick(); resolve(0, 0, 0, 0);
      chk("nt1_pc", pc_o, 32'h14); chk("nt1_vd", validD_o, 0); chk("nt1_cnt", mispred_cnt_o, 3);

      // 0x14 jumps back to 0x10
      tick(); chk("j14_pcd", pcD_o, 32'h14);
      resolve(1, 1, 1, 32'h10);
      tick(); resolve(0, 0, 0, 0);
      chk("j14_pc", pc_o, 32'h10); chk("j14_cnt", mispred_cnt_o, 4);

      // second not-taken (cnt 2->1); still predicted taken this time
      tick(); chk("nt2_pc", pc_o, 32'h40); chk("nt2_predt", pred_takenD_o, 1);
      resolve(1, 0, 0, 0);
      chk("nt2_flush", flush_o, 1);
      tick(); resolve(0, 0, 0, 0);
      chk("nt2_pc_r", pc_o, 32'h14); chk("nt2_cnt", mispred_cnt_o, 5);

      // 0x14 predicted taken to 0x10, then 0x10 predicted not taken
      tick(); chk("p14_pc", pc_o, 32'h10); chk("p14_predt", pred_takenD_o, 1);
      chk("p14_predtg", pred_targetD_o, 32'h10);
      tick(); chk("nt3_pc", pc_o, 32'h14); chk("nt3_pcd", pcD_o, 32'h10);
      chk("nt3_predt", pred_takenD_o, 0);
      resolve(1, 0, 0, 0);
      chk("nt3_flush", flush_o, 0);
      tick(); resolve(0, 0, 0, 0);
      chk("nt3_cnt", mispred_cnt_o, 5); chk("nt3_pc_n", pc_o, 32'h10);

      // stall holds everything for three edges
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stl_pc", pc_o, 32'h10); chk("stl_pcd", pcD_o, 32'h14); chk("stl_vd", validD_o, 1);
      end
      // mispredict while stalled: target differs from predicted 0x10
      resolve(1, 1, 0, 32'h80);
      chk("stl_flush", flush_o, 1);
      tick(); resolve(0, 0, 0, 0);
      chk("stl_pc_r", pc_o, 32'h80); chk("stl_vd_r", validD_o, 0); chk("stl_cnt", mispred_cnt_o, 6);
      stall_i = 1'b0;

      // alias: 0x50 shares index 4 with 0x10
      tick(); chk("al_pcd", pcD_o, 32'h80);
      resolve(1, 1, 1, 32'h50);
      tick(); resolve(0, 0, 0, 0);
      chk("al_pc50", pc_o, 32'h50);
      tick(); chk("al_predt50", pred_takenD_o, 0); chk("al_pc54", pc_o, 32'h54);
      resolve(1, 1, 0, 32'h10);
      chk("al_flush", flush_o, 1);
      tick(); resolve(0, 0, 0, 0);
      chk("al_pc10", pc_o, 32'h10); chk("al_cnt", mispred_cnt_o, 8);
      tick(); chk("al_evict_pc", pc_o, 32'h14); chk("al_evict_predt", pred_takenD_o, 0);
      chk("al_evict_vd", validD_o, 1); chk("al_evict_flush", flush_o, 0);

      // asynchronous reset mid-operation
      #2 rst = 1'b1;
      #1;
      chk("arst_pc", pc_o, 32'h0); chk("arst_vd", validD_o, 0); chk("arst_pcd", pcD_o, 32'h0);
      chk("arst_cnt", mispred_cnt_o, 0); chk("arst_flush", flush_o, 0);
      tick();
      rst = 1'b0;
      tick(); chk("post_pc", pc_o, 32'h4); chk("post_vd", validD_o, 1); chk("post_predt", pred_takenD_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
